// File: rtl/forward_neuron_if.sv
// Stream bundle for forward_neuron: start/bias, (x, w) input pairs, and
// the net/activated result handshake.
interface forward_neuron_if;
  logic        start;
  logic [31:0] bias;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] x_in;
  logic [31:0] w_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] net_out;
  logic [31:0] act_out;
  logic        busy;

  modport master (
    output start, bias, in_valid, x_in, w_in, out_ready,
    input  in_ready, out_valid, net_out, act_out, busy
  );

  modport slave (
    input  start, bias, in_valid, x_in, w_in, out_ready,
    output in_ready, out_valid, net_out, act_out, busy
  );
endinterface

// File: rtl/forward_neuron.sv
// Sequential single-neuron forward pass: acc = bias + sum(x*w), then
// hard-sigmoid clamp(0.25*acc + 0.5, 0, 1), both presented on a valid/ready output.
module forward_neuron #(
  parameter int unsigned N_INPUTS = 2,
  parameter logic [31:0] QUARTER  = 32'h3E800000,
  parameter logic [31:0] HALF     = 32'h3F000000,
  parameter logic [31:0] ONE      = 32'h3F800000
) (
  input logic             clk,
  input logic             rst_n,
  forward_neuron_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ACCUM, ACT, DONE} state_t;

  localparam logic [7:0] LAST = 8'(N_INPUTS - 1);

  state_t      state, state_nxt;
  logic [31:0] acc;
  logic [7:0]  cnt;
  logic [31:0] net_r;
  logic [31:0] act_r;
  logic        fire;
  logic [31:0] prod;
  logic [31:0] acc_sum;
  logic [31:0] y;

  // Round-to-nearest-even on a normalised fraction; subnormals flush to zero.
  function automatic logic [31:0] round_pack(input logic sgn, input int e_in,
                                             input logic [22:0] frac,
                                             input logic g, input logic st);
    logic [23:0] m;
    int          e;
    e = e_in;
    m = {1'b0, frac};
    if (g && (st || frac[0])) m = m + 24'd1;
    if (m[23]) begin
      e = e + 1;
      m = 24'd0;
    end
    if (e >= 255) return {sgn, 8'hFF, 23'd0};
    if (e <= 0) return {sgn, 31'd0};
    return {sgn, e[7:0], m[22:0]};
  endfunction

  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    logic        sgn;
    logic [47:0] p;
    int          e;
    sgn = a[31] ^ b[31];
    if (a[30:23] == 8'hFF) return {sgn, a[30:0]};
    if (b[30:23] == 8'hFF) return {sgn, b[30:0]};
    if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return {sgn, 31'd0};
    p = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
    e = int'(a[30:23]) + int'(b[30:23]) - 127;
    if (p[47]) return round_pack(sgn, e + 1, p[46:24], p[23], |p[22:0]);
    return round_pack(sgn, e, p[45:23], p[22], |p[21:0]);
  endfunction

  function automatic logic [31:0] fadd(input logic [31:0] a_in, input logic [31:0] b_in);
    logic [31:0] a, b;
    logic [49:0] ext;
    logic [26:0] ma, mb;
    logic [27:0] s;
    int          e, d;
    if (a_in[30:23] == 8'hFF) return a_in;
    if (b_in[30:23] == 8'hFF) return b_in;
    if (a_in[30:23] == 8'd0 && b_in[30:23] == 8'd0) return {a_in[31] & b_in[31], 31'd0};
    if (a_in[30:23] == 8'd0) return b_in;
    if (b_in[30:23] == 8'd0) return a_in;
    if (a_in[30:0] >= b_in[30:0]) begin
      a = a_in;
      b = b_in;
    end else begin
      a = b_in;
      b = a_in;
    end
    e   = int'(a[30:23]);
    d   = e - int'(b[30:23]);
    ma  = {1'b1, a[22:0], 3'b000};
    ext = {1'b1, b[22:0], 26'd0} >> d;
    mb  = {ext[49:24], |ext[23:0]};
    if (a[31] == b[31]) begin
      s = {1'b0, ma} + {1'b0, mb};
      if (s[27]) begin
        s = {1'b0, s[27:2], s[1] | s[0]};
        e = e + 1;
      end
    end else begin
      s = {1'b0, ma} - {1'b0, mb};
      if (s == 28'd0) return 32'd0;
      for (int i = 0; i < 27; i++) begin
        if (!s[26]) begin
          s = s << 1;
          e = e - 1;
        end
      end
    end
    return round_pack(a[31], e, s[25:3], s[2], |s[1:0]);
  endfunction

  // Negative results (including -0) clamp to +0; anything at or above 1.0 saturates.
  function automatic logic [31:0] hard_clamp(input logic [31:0] v);
    if (v[31]) return 32'd0;
    if (v[30:0] >= ONE[30:0]) return ONE;
    return v;
  endfunction

  assign fire    = bus.in_valid && (state == ACCUM);
  assign prod    = fmul(bus.x_in, bus.w_in);
  assign acc_sum = fadd(acc, prod);
  assign y       = fadd(fmul(acc, QUARTER), HALF);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = ACCUM;
      ACCUM:   if (fire && cnt == LAST) state_nxt = ACT;
      ACT:     state_nxt = DONE;
      DONE:    if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc   <= 32'd0;
      cnt   <= 8'd0;
      net_r <= 32'd0;
      act_r <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            acc <= bus.bias;
            cnt <= 8'd0;
          end
        end
        ACCUM: begin
          if (fire) begin
            acc <= acc_sum;
            cnt <= cnt + 8'd1;
          end
        end
        ACT: begin
          net_r <= acc;
          act_r <= hard_clamp(y);
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state == ACCUM);
  assign bus.out_valid = (state == DONE);
  assign bus.busy      = (state != IDLE);
  assign bus.net_out   = net_r;
  assign bus.act_out   = act_r;

endmodule
